// File: rtl/separable_switch_allocator_pkg.sv
// Shared router types for the switch allocator: port indexing and lock ownership.
package separable_switch_allocator_pkg;

   localparam int PORT_NUM = 5;
   localparam int PORT_W   = $clog2(PORT_NUM);

   // Wide enough for any VC count this allocator is built with (up to 16).
   localparam int VC_IDX_W = 4;

   typedef logic [PORT_W-1:0]   port_t;
   typedef logic [VC_IDX_W-1:0] vc_idx_t;

   typedef struct packed {
      port_t   port;
      vc_idx_t vc;
   } lock_owner_t;

endpackage

// File: rtl/separable_switch_allocator_arb.sv
// Round-robin arbiter whose priority pointer only advances when told that
// its winner was actually used (iSLIP-style update).
module round_robin_arbiter_upd #(
   parameter int AGENTS_NUM = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [AGENTS_NUM-1:0] requests_i,
   input  logic                  update_i,
   output logic [AGENTS_NUM-1:0] grants_o
);

   localparam int PTR_W = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] winner;
   logic             found;

   // Pick the first requester at or after the pointer, wrapping to 0; compute next pointer.
   always_comb begin
      grants_o = '0;
      winner   = '0;
      found    = 1'b0;
      for (int i = 0; i < AGENTS_NUM; i++) begin
         if (!found && requests_i[i] && (i >= int'(ptr_q))) begin
            found       = 1'b1;
            winner      = PTR_W'(i);
            grants_o[i] = 1'b1;
         end
      end
      for (int i = 0; i < AGENTS_NUM; i++) begin
         if (!found && requests_i[i] && (i < int'(ptr_q))) begin
            found       = 1'b1;
            winner      = PTR_W'(i);
            grants_o[i] = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (update_i && found) begin
         ptr_d = (winner == PTR_W'(AGENTS_NUM - 1)) ? '0 : winner + PTR_W'(1);
      end
   end

   // Pointer register; reset gives agent 0 top priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
   end

endmodule

// File: rtl/separable_switch_allocator.sv
// Registered two-stage separable switch allocator with per-output packet
// locking, output-ready masking and grant-qualified round-robin updates.
module separable_switch_allocator
   import separable_switch_allocator_pkg::*;
#(
   parameter int VC_NUM      = 2,
   parameter int FIRST_STAGE = 0,
   parameter int LOCK_EN     = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0] request_i,
   input  port_t [PORT_NUM-1:0][VC_NUM-1:0] out_port_i,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0] tail_i,
   input  logic  [PORT_NUM-1:0]             out_ready_i,
   output logic  [PORT_NUM-1:0][VC_NUM-1:0] grant_o,
   output logic  [PORT_NUM-1:0]             locked_o
);

   logic [PORT_NUM-1:0][VC_NUM-1:0] eff, tgt_lock, force_gnt, elig;
   logic [PORT_NUM-1:0][VC_NUM-1:0] vc_req, vc_gnt, arb_gnt;
   logic [PORT_NUM-1:0][VC_NUM-1:0] grant_q, grant_d;
   logic [PORT_NUM-1:0]             in_lock_win, vc_upd, out_upd, lock_vld;
   logic [PORT_NUM-1:0]             lock_vld_q, lock_vld_d;
   lock_owner_t [PORT_NUM-1:0]      lock_own_q, lock_own_d;
   // Indexed [output][input].
   logic [PORT_NUM-1:0][PORT_NUM-1:0] out_req, out_gnt, fin_to;

   assign lock_vld = (LOCK_EN != 0) ? lock_vld_q : '0;

   // Qualify requests by output readiness, find lock-forced winners, and build the arbitration set.
   always_comb begin
      eff         = '0;
      tgt_lock    = '0;
      force_gnt   = '0;
      elig        = '0;
      in_lock_win = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (32'(out_port_i[p][v]) < PORT_NUM) begin
               eff[p][v] = request_i[p][v] & out_ready_i[out_port_i[p][v]];
            end
         end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               if (out_port_i[p][v] == port_t'(o) && lock_vld[o]) begin
                  tgt_lock[p][v] = 1'b1;
                  if (lock_own_q[o].port == port_t'(p) && lock_own_q[o].vc == vc_idx_t'(v)
                      && eff[p][v]) begin
                     force_gnt[p][v] = 1'b1;
                  end
               end
            end
         end
      end
      for (int p = 0; p < PORT_NUM; p++) begin
         in_lock_win[p] = |force_gnt[p];
         for (int v = 0; v < VC_NUM; v++) begin
            elig[p][v] = eff[p][v] & ~tgt_lock[p][v] & ~in_lock_win[p];
         end
      end
   end

   if (FIRST_STAGE == 0) begin : g_input_first
      // Inputs pick a VC first.
      always_comb vc_req = elig;

      // Each input's chosen VC bids for its target output.
      always_comb begin
         out_req = '0;
         for (int o = 0; o < PORT_NUM; o++)
            for (int p = 0; p < PORT_NUM; p++)
               for (int v = 0; v < VC_NUM; v++)
                  if (vc_gnt[p][v] && out_port_i[p][v] == port_t'(o)) out_req[o][p] = 1'b1;
      end

      // A chosen VC is granted when its output also chose this input.
      always_comb begin
         arb_gnt = '0;
         for (int o = 0; o < PORT_NUM; o++)
            for (int p = 0; p < PORT_NUM; p++)
               for (int v = 0; v < VC_NUM; v++)
                  if (vc_gnt[p][v] && out_port_i[p][v] == port_t'(o) && out_gnt[o][p])
                     arb_gnt[p][v] = 1'b1;
      end
   end else begin : g_output_first
      // Outputs pick among inputs with any eligible VC aimed at them.
      always_comb begin
         out_req = '0;
         for (int o = 0; o < PORT_NUM; o++)
            for (int p = 0; p < PORT_NUM; p++)
               for (int v = 0; v < VC_NUM; v++)
                  if (elig[p][v] && out_port_i[p][v] == port_t'(o)) out_req[o][p] = 1'b1;
      end

      // Inputs then pick one VC among those whose output granted this input.
      always_comb begin
         vc_req = '0;
         for (int o = 0; o < PORT_NUM; o++)
            for (int p = 0; p < PORT_NUM; p++)
               for (int v = 0; v < VC_NUM; v++)
                  if (elig[p][v] && out_port_i[p][v] == port_t'(o) && out_gnt[o][p])
                     vc_req[p][v] = 1'b1;
      end

      // The input-stage choice is final.
      always_comb arb_gnt = vc_gnt;
   end

   for (genvar g = 0; g < PORT_NUM; g++) begin : g_arb
      round_robin_arbiter_upd #(.AGENTS_NUM(VC_NUM)) u_vc_arb (
         .clk        (clk),
         .rst        (rst),
         .requests_i (vc_req[g]),
         .update_i   (vc_upd[g]),
         .grants_o   (vc_gnt[g])
      );
      round_robin_arbiter_upd #(.AGENTS_NUM(PORT_NUM)) u_out_arb (
         .clk        (clk),
         .rst        (rst),
         .requests_i (out_req[g]),
         .update_i   (out_upd[g]),
         .grants_o   (out_gnt[g])
      );
   end

   // Final grants; pointers advance only when their arbiter's winner was finally granted.
   always_comb begin
      grant_d = arb_gnt | force_gnt;
      fin_to  = '0;
      vc_upd  = '0;
      out_upd = '0;
      for (int o = 0; o < PORT_NUM; o++)
         for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++)
               if (arb_gnt[p][v] && out_port_i[p][v] == port_t'(o)) fin_to[o][p] = 1'b1;
      for (int p = 0; p < PORT_NUM; p++) begin
         vc_upd[p]  = |(vc_gnt[p] & arb_gnt[p]);
         out_upd[p] = |(out_gnt[p] & fin_to[p]);
      end
   end

   // Lock bookkeeping: non-tail grant on a free output claims it, owner tail releases it.
   always_comb begin
      lock_vld_d = lock_vld_q;
      lock_own_d = lock_own_q;
      if (LOCK_EN != 0) begin
         for (int o = 0; o < PORT_NUM; o++)
            for (int p = 0; p < PORT_NUM; p++)
               for (int v = 0; v < VC_NUM; v++)
                  if (grant_d[p][v] && out_port_i[p][v] == port_t'(o)) begin
                     if (lock_vld_q[o]) begin
                        if (tail_i[p][v]) lock_vld_d[o] = 1'b0;
                     end else if (!tail_i[p][v]) begin
                        lock_vld_d[o]      = 1'b1;
                        lock_own_d[o].port = port_t'(p);
                        lock_own_d[o].vc   = vc_idx_t'(v);
                     end
                  end
      end else begin
         lock_vld_d = '0;
      end
   end

   // Grant and lock registers; reset drops every lock immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_q    <= '0;
         lock_vld_q <= '0;
         lock_own_q <= '0;
      end else begin
         grant_q    <= grant_d;
         lock_vld_q <= lock_vld_d;
         lock_own_q <= lock_own_d;
      end
   end

   assign grant_o  = grant_q;
   assign locked_o = lock_vld;

endmodule

// File: tb/tb_separable_switch_allocator.sv
// Directed bench for the separable switch allocator, input-first and output-first builds.
module tb_separable_switch_allocator;
   import separable_switch_allocator_pkg::*;

   logic                        clk;
   logic                        rst;
   logic  [PORT_NUM-1:0][1:0]   request;
   port_t [PORT_NUM-1:0][1:0]   out_port;
   logic  [PORT_NUM-1:0][1:0]   tail;
   logic  [PORT_NUM-1:0]        out_ready;
   logic  [PORT_NUM-1:0][1:0]   gi, go;
   logic  [PORT_NUM-1:0]        li, lo;

   int total = 0;
   int bad   = 0;

   separable_switch_allocator #(.VC_NUM(2), .FIRST_STAGE(0), .LOCK_EN(1)) dut (
      .clk(clk), .rst(rst), .request_i(request), .out_port_i(out_port),
      .tail_i(tail), .out_ready_i(out_ready), .grant_o(gi), .locked_o(li)
   );

   separable_switch_allocator #(.VC_NUM(2), .FIRST_STAGE(1), .LOCK_EN(1)) dut_of (
      .clk(clk), .rst(rst), .request_i(request), .out_port_i(out_port),
      .tail_i(tail), .out_ready_i(out_ready), .grant_o(go), .locked_o(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] gb(input int p, input int v);
      logic [9:0] r;
      r = '0;
      r[p*2+v] = 1'b1;
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      request   = '0;
      out_port  = '0;
      tail      = '0;
      out_ready = '1;
   endtask

   task automatic set_req(input int p, input int v, input int o, input int t);
      request[p][v]  = 1'b1;
      out_port[p][v] = port_t'(o);
      tail[p][v]     = (t != 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      total++; if (gi !== 10'b0) begin bad++; $display("FAIL reset_grant got %b want %b", gi, 10'b0); end
      total++; if (li !== 5'b0) begin bad++; $display("FAIL reset_locked got %b want %b", li, 5'b0); end
      @(negedge clk);
      rst = 1'b1;
      set_req(1, 1, 2, 0);
      cyc();
      total++; if (gi !== gb(1, 1)) begin bad++; $display("FAIL prelock_grant got %b want %b", gi, gb(1, 1)); end
      total++; if (li !== 5'b00100) begin bad++; $display("FAIL prelock_locked got %b want %b", li, 5'b00100); end
      #3;
      rst = 1'b0;
      #1;
      total++; if (gi !== 10'b0) begin bad++; $display("FAIL async_grant got %b want %b", gi, 10'b0); end
      total++; if (li !== 5'b0) begin bad++; $display("FAIL async_locked got %b want %b", li, 5'b0); end
      total++; if (lo !== 5'b0) begin bad++; $display("FAIL async_locked_of got %b want %b", lo, 5'b0); end
      cyc();
      total++; if (gi !== 10'b0) begin bad++; $display("FAIL in_reset_grant got %b want %b", gi, 10'b0); end
      clear_inputs();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         total++; if (gi !== 10'b0) begin bad++; $display("FAIL idle_grant got %b want %b", gi, 10'b0); end
         total++; if (go !== 10'b0) begin bad++; $display("FAIL idle_grant_of got %b want %b", go, 10'b0); end
      end
   endtask

   task automatic test_contention();
      do_reset();
      set_req(0, 0, 3, 1);
      set_req(1, 0, 3, 1);
      set_req(2, 0, 3, 1);
      for (int i = 0; i < 6; i++) begin
         cyc();
         total++; if (gi !== gb(i % 3, 0)) begin bad++; $display("FAIL contention_if[%0d] got %b want %b", i, gi, gb(i % 3, 0)); end
         total++; if (go !== gb(i % 3, 0)) begin bad++; $display("FAIL contention_of[%0d] got %b want %b", i, go, gb(i % 3, 0)); end
         total++; if ((li | lo) !== 5'b0) begin bad++; $display("FAIL contention_locked[%0d] got %b/%b want 0", i, li, lo); end
      end
   endtask

   task automatic test_packet_lock();
      logic [4:0] exp_lock [3];
      exp_lock[0] = 5'b00100;
      exp_lock[1] = 5'b00100;
      exp_lock[2] = 5'b00000;
      do_reset();
      set_req(1, 1, 2, 0);
      set_req(4, 0, 2, 1);
      for (int f = 0; f < 3; f++) begin
         tail[1][1] = (f == 2);
         cyc();
         total++; if (gi !== gb(1, 1)) begin bad++; $display("FAIL lock_grant_if[%0d] got %b want %b", f, gi, gb(1, 1)); end
         total++; if (go !== gb(1, 1)) begin bad++; $display("FAIL lock_grant_of[%0d] got %b want %b", f, go, gb(1, 1)); end
         total++; if (li !== exp_lock[f]) begin bad++; $display("FAIL lock_state_if[%0d] got %b want %b", f, li, exp_lock[f]); end
         total++; if (lo !== exp_lock[f]) begin bad++; $display("FAIL lock_state_of[%0d] got %b want %b", f, lo, exp_lock[f]); end
      end
      request[1][1] = 1'b0;
      cyc();
      total++; if (gi !== gb(4, 0)) begin bad++; $display("FAIL lock_after_if got %b want %b", gi, gb(4, 0)); end
      total++; if (go !== gb(4, 0)) begin bad++; $display("FAIL lock_after_of got %b want %b", go, gb(4, 0)); end
   endtask

   task automatic test_owner_bubble();
      do_reset();
      set_req(1, 1, 2, 0);
      set_req(4, 0, 2, 1);
      cyc();
      total++; if (gi !== gb(1, 1)) begin bad++; $display("FAIL bubble_head got %b want %b", gi, gb(1, 1)); end
      request[1][1] = 1'b0;
      set_req(1, 0, 0, 1);
      for (int i = 0; i < 2; i++) begin
         cyc();
         total++; if (gi !== gb(1, 0)) begin bad++; $display("FAIL bubble_grant_if[%0d] got %b want %b", i, gi, gb(1, 0)); end
         total++; if (go !== gb(1, 0)) begin bad++; $display("FAIL bubble_grant_of[%0d] got %b want %b", i, go, gb(1, 0)); end
         total++; if (li !== 5'b00100) begin bad++; $display("FAIL bubble_locked[%0d] got %b want %b", i, li, 5'b00100); end
      end
      request[1][1] = 1'b1;
      cyc();
      total++; if (gi !== gb(1, 1)) begin bad++; $display("FAIL bubble_resume_if got %b want %b", gi, gb(1, 1)); end
      total++; if (go !== gb(1, 1)) begin bad++; $display("FAIL bubble_resume_of got %b want %b", go, gb(1, 1)); end
      total++; if (li !== 5'b00100) begin bad++; $display("FAIL bubble_resume_locked got %b want %b", li, 5'b00100); end
      tail[1][1] = 1'b1;
      cyc();
      total++; if (gi !== gb(1, 1)) begin bad++; $display("FAIL bubble_tail got %b want %b", gi, gb(1, 1)); end
      total++; if (li !== 5'b0) begin bad++; $display("FAIL bubble_unlock got %b want %b", li, 5'b0); end
      request[1][1] = 1'b0;
      cyc();
      total++; if (gi !== (gb(4, 0) | gb(1, 0))) begin bad++; $display("FAIL bubble_release_if got %b want %b", gi, gb(4, 0) | gb(1, 0)); end
      total++; if (go !== (gb(4, 0) | gb(1, 0))) begin bad++; $display("FAIL bubble_release_of got %b want %b", go, gb(4, 0) | gb(1, 0)); end
   endtask

   task automatic test_islip();
      do_reset();
      set_req(2, 0, 1, 1);
      cyc();
      total++; if (gi !== gb(2, 0)) begin bad++; $display("FAIL islip_prime got %b want %b", gi, gb(2, 0)); end
      clear_inputs();
      set_req(0, 0, 1, 1);
      set_req(0, 1, 2, 1);
      set_req(3, 0, 1, 1);
      cyc();
      total++; if (gi !== gb(3, 0)) begin bad++; $display("FAIL islip_c1 got %b want %b", gi, gb(3, 0)); end
      cyc();
      total++; if (gi !== gb(0, 0)) begin bad++; $display("FAIL islip_c2 got %b want %b", gi, gb(0, 0)); end
      cyc();
      total++; if (gi !== (gb(0, 1) | gb(3, 0))) begin bad++; $display("FAIL islip_c3 got %b want %b", gi, gb(0, 1) | gb(3, 0)); end
   endtask

   task automatic test_ready_mask();
      do_reset();
      out_ready[4] = 1'b0;
      set_req(2, 1, 4, 1);
      for (int i = 0; i < 2; i++) begin
         cyc();
         total++; if (gi !== 10'b0) begin bad++; $display("FAIL mask_if[%0d] got %b want %b", i, gi, 10'b0); end
         total++; if (go !== 10'b0) begin bad++; $display("FAIL mask_of[%0d] got %b want %b", i, go, 10'b0); end
      end
      out_ready[4] = 1'b1;
      cyc();
      total++; if (gi !== gb(2, 1)) begin bad++; $display("FAIL unmask_if got %b want %b", gi, gb(2, 1)); end
      total++; if (go !== gb(2, 1)) begin bad++; $display("FAIL unmask_of got %b want %b", go, gb(2, 1)); end
      request = '0;
      cyc();
      total++; if (gi !== 10'b0) begin bad++; $display("FAIL no_sticky got %b want %b", gi, 10'b0); end
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      test_reset();
      test_contention();
      test_packet_lock();
      test_owner_bubble();
      test_islip();
      test_ready_mask();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/separable_switch_allocator.md
Name: separable_switch_allocator

Overview:
- Parametrised, registered successor to the combinational separable switch allocator.
- Performs two-stage separable allocation of crossbar input ports to output ports. The order is selectable: input-first or output-first.
- Adds three behaviours:
  - per-output-port packet locking, so a multi-flit packet holds the output until its tail flit;
  - output-ready masking;
  - iSLIP-style round-robin pointer update, applied only on final grants.
- Sits between the VC/input units and the crossbar in the router pipeline (switch-allocation stage).

Parameters:
- VC_NUM, 2: virtual channels per input port.
- FIRST_STAGE, 0: 0 = input-first; 1 = output-first.
- LOCK_EN, 1: 1 = enable packet locking of output ports; 0 = per-flit allocation.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- request_i  in  [PORT_NUM][VC_NUM]  VC requests a crossbar traversal this cycle.
- out_port_i  in  port_t[VC_NUM] x PORT_NUM  destination output port for each VC's request.
- tail_i  in  [PORT_NUM][VC_NUM]  the requesting flit of this VC is a tail (or head+tail) flit.
- out_ready_i  in  [PORT_NUM]  output port can accept a flit (downstream credit available).
- grant_o  out  [PORT_NUM][VC_NUM]  registered grant, one cycle after request.
- locked_o  out  [PORT_NUM]  registered lock state per output port (for debug/verification).

Behaviour:
- Reset (rst=0, asynchronous):
  - grant_o=0 and locked_o=0;
  - all lock owners cleared;
  - every round-robin pointer gives agent 0 highest priority.
- Reset mid-packet drops all locks immediately. Inputs are not re-sampled until rst=1.
- Latency: grant_o is a combinational allocation result computed from cycle-N inputs and registered at the edge ending cycle N. It is visible in cycle N+1 and held for exactly one cycle; there is no stickiness.
- Effective request: request_i[p][v] & out_ready_i[out_port_i[p][v]]. A request to a non-ready output is ignored for that cycle.
- Locked output o, owned by (p,v):
  - only (p,v) may be granted o, and no arbitration is performed for o;
  - if (p,v) has an effective request, it wins both stages unconditionally;
  - input p's other VCs are excluded this cycle.
- If the lock owner does not request, o stays idle and stays locked. Input p's other VCs may then compete for other unlocked outputs.
- Unlocked outputs, input-first mode:
  - each input arbiter selects one VC among that input's effective requests not targeting locked outputs, excluding inputs that hold a winning lock owner;
  - each output arbiter then selects one input among the first-stage winners targeting it.
- Unlocked outputs, output-first mode:
  - each output arbiter selects among inputs with any eligible VC targeting it;
  - each input arbiter then selects one VC among its VCs whose target output granted this input.
- Invariants, checked every cycle:
  - at most one grant per input port row;
  - at most one grant per output port (over all VCs mapping to it);
  - a grant is only ever given to an effective request.
- Pointer update:
  - an arbiter's pointer moves to the position just after its winner only if that winner received a final grant_o;
  - a first-stage winner that loses the second stage leaves its first-stage pointer unchanged;
  - lock-forced grants do not update pointers.
- Lock update, at the same edge as grant_o (LOCK_EN=1):
  - granted (p,v) to o with tail_i=0 on an unlocked o sets lock o with owner (p,v);
  - granted owner with tail_i=1 clears lock o;
  - head+tail (tail_i=1 on an unlocked grant) never sets the lock.
- LOCK_EN=0: locked_o is held at 0 and lock logic is removed.
- Wrap-around: round-robin priority wraps from index N-1 to 0.
- Same-edge set and clear of one lock is impossible by construction: one grant per output.

Decomposition:
- noc_params package: PORT_NUM, port_t (already present). Add lock_owner_t {port index, VC index} there.
- One natural sub-module: round_robin_arbiter_upd (AGENTS_NUM parameter; requests_i, update_i, grants_o), which advances its priority pointer only when update_i=1.
- Instantiate PORT_NUM arbiters of width VC_NUM and PORT_NUM of width PORT_NUM. Their roles swap with FIRST_STAGE.

Test Plan:
- Reset then idle: rst=0 mid-cycle → grant_o=0 and locked_o=0 asynchronously; no grants while request_i=0.
- Contention: PORT_NUM=5, VC_NUM=2, inputs 0,1,2 VC0 all request output 3 with tail=1, every cycle for 6 cycles → grant_o rotates input 0,1,2,0,1,2 (one per cycle, 1-cycle latency); locked_o stays 0.
- Packet lock: input 1 VC1 sends a 3-flit packet to output 2 (tail on flit 3) while input 4 VC0 also requests output 2 → input 1 VC1 is granted on 3 consecutive cycles; locked_o[2]=1 after flits 1 and 2, and 0 after flit 3; input 4 is granted next.
- Owner bubble: lock owner deasserts request for 2 cycles mid-packet → no grant to that output, locked_o stays 1, other input's requests to it are denied; the owner resumes and completes the packet.
- iSLIP pointer: input-first, input 0 VC0→out 1 and VC1→out 2, input 3 VC0→out 1 wins out 1 → input 0's VC pointer is unchanged, so VC0 is selected again next cycle.
- Ready masking / output-first: out_ready_i[4]=0 with requests to output 4 → no grant; release it → grant next edge. Repeat the contention case with FIRST_STAGE=1 → same fairness, one grant per row and column.
